// File: rtl/dram_arb_pkg.sv
// Shared types and default sizing for the two-core DRAM arbiter.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    localparam int NREQ_DEF = 2;
    localparam int AW_DEF   = 8;
    localparam int DW_DEF   = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first pending index at or after ptr.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any
);

    always_comb begin
        // NOTE: outputs get defaults first so every path assigns them and no latch is inferred.
        winner = '0;
        any    = 1'b0;
        // Scan from the farthest offset down so the nearest pending index is assigned last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pending[IW'((int'(ptr) + k) % NREQ)]) begin
                winner = IW'((int'(ptr) + k) % NREQ);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM between NREQ cores,
// with a one-cycle acq pulse per completed access.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   rden,
    input  logic [NREQ-1:0]   wren,
    input  logic [NREQ*AW-1:0] Address,
    input  logic [NREQ*DW-1:0] Din,
    input  logic [DW-1:0]     RAMq,
    output logic [NREQ-1:0]   acq,
    output logic [NREQ*DW-1:0] Dq,
    output logic [AW-1:0]     RAMAddress,
    output logic [DW-1:0]     RAMDin,
    output logic              RAMwren
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   next_ptr;
    logic            any;
    logic [NREQ-1:0] pending;
    logic [DW-1:0]   dq_hold [NREQ];

    assign pending  = rden | wren;
    assign next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .pending (pending),
        .ptr     (ptr),
        .winner  (winner),
        .any     (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            RAMAddress <= '0;
            RAMDin     <= '0;
            RAMwren    <= 1'b0;
            acq        <= '0;
            // NOTE: dq_hold is a handful of registers whose reset value is visible on Dq, so it is reset like any other state.
            for (int i = 0; i < NREQ; i++) begin
                dq_hold[i] <= '0;
            end
        end else begin
            acq <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        owner      <= winner;
                        RAMAddress <= Address[int'(winner)*AW +: AW];
                        // A request with both rden and wren set is a write.
                        if (wren[winner]) begin
                            RAMDin  <= Din[int'(winner)*DW +: DW];
                            RAMwren <= 1'b1;
                            acq     <= NREQ'(1) << winner;
                            state   <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                WR: begin
                    RAMwren <= 1'b0;
                    ptr     <= next_ptr;
                    state   <= IDLE;
                end
                RD: begin
                    acq   <= NREQ'(1) << owner;
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    dq_hold[owner] <= RAMq;
                    ptr            <= next_ptr;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The owner sees RAMq directly in its data cycle; otherwise the last read value.
    always_comb begin
        Dq = '0;
        for (int i = 0; i < NREQ; i++) begin
            Dq[i*DW +: DW] = (state == RD_DATA && owner == IW'(i)) ? RAMq : dq_hold[i];
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural single-port DRAM.
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rden;
    logic [1:0]  wren;
    logic [15:0] Address;
    logic [15:0] Din;
    logic [7:0]  RAMq;
    logic [1:0]  acq;
    logic [15:0] Dq;
    logic [7:0]  RAMAddress;
    logic [7:0]  RAMDin;
    logic        RAMwren;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    // DRAM: synchronous write, read data one cycle after the address is sampled.
    always @(posedge clk) begin
        if (RAMwren) mem[RAMAddress] <= RAMDin;
        RAMq <= mem[RAMAddress];
    end

    dram_arbiter #(
        .NREQ (2),
        .AW   (8),
        .DW   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rden       (rden),
        .wren       (wren),
        .Address    (Address),
        .Din        (Din),
        .RAMq       (RAMq),
        .acq        (acq),
        .Dq         (Dq),
        .RAMAddress (RAMAddress),
        .RAMDin     (RAMDin),
        .RAMwren    (RAMwren)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] exp_acq;

        rst = 1'b1; rden = '0; wren = '0; Address = '0; Din = '0;
        tick();
        tick();
        check("rst_acq",     32'(acq),        32'h0);
        check("rst_ramwren", 32'(RAMwren),    32'h0);
        check("rst_ramaddr", 32'(RAMAddress), 32'h0);
        check("rst_ramdin",  32'(RAMDin),     32'h0);
        check("rst_dq",      32'(Dq),         32'h0);
        rst = 1'b0;

        // Single write by core0: WR one cycle later with acq=01.
        wren = 2'b01; Address[7:0] = 8'h10; Din[7:0] = 8'hA5;
        tick();
        check("wr_ramwren", 32'(RAMwren),    32'h1);
        check("wr_ramaddr", 32'(RAMAddress), 32'h10);
        check("wr_ramdin",  32'(RAMDin),     32'hA5);
        check("wr_acq",     32'(acq),        32'h1);
        wren = 2'b00;
        tick();
        check("wr_done_acq",     32'(acq),       32'h0);
        check("wr_done_ramwren", 32'(RAMwren),   32'h0);
        check("wr_mem",          32'(mem[8'h10]), 32'hA5);

        // Single read by core1 (ptr=1): acq=10 two cycles after the request.
        rden = 2'b10; Address[15:8] = 8'h10;
        tick();
        check("rd_wait_acq", 32'(acq), 32'h0);
        tick();
        check("rd_acq", 32'(acq),      32'h2);
        check("rd_dq1", 32'(Dq[15:8]), 32'hA5);
        rden = 2'b00;
        tick();
        check("rd_idle_acq", 32'(acq),      32'h0);
        check("rd_hold_dq1", 32'(Dq[15:8]), 32'hA5);

        // rden and wren together on core0 is a write; Dq[0] untouched.
        rden = 2'b01; wren = 2'b01; Address[7:0] = 8'h01; Din[7:0] = 8'h11;
        tick();
        check("rw_ramwren", 32'(RAMwren),   32'h1);
        check("rw_acq",     32'(acq),       32'h1);
        check("rw_ramdin",  32'(RAMDin),    32'h11);
        check("rw_dq0",     32'(Dq[7:0]),   32'h0);
        rden = 2'b00; wren = 2'b00;
        tick();
        check("rw_mem",       32'(mem[8'h01]), 32'h11);
        check("rw_dq0_after", 32'(Dq[7:0]),    32'h0);

        // Core1 writes 0x22 to 0x02 (ptr=1).
        wren = 2'b10; Address[15:8] = 8'h02; Din[15:8] = 8'h22;
        tick();
        check("w1_acq",     32'(acq),        32'h2);
        check("w1_ramaddr", 32'(RAMAddress), 32'h02);
        wren = 2'b00;
        tick();

        // Reset between transactions clears dq_hold and ptr.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_dq1", 32'(Dq[15:8]), 32'h0);

        // Contention: continuous reads from both cores, grants 0,1,0,1 three cycles apart.
        rden = 2'b11; Address = {8'h02, 8'h01};
        for (int c = 0; c < 12; c++) begin
            exp_acq = (c % 6 == 2) ? 2'b01 : (c % 6 == 5) ? 2'b10 : 2'b00;
            check($sformatf("cont_acq_%0d", c), 32'(acq), 32'(exp_acq));
            if (exp_acq == 2'b01) check($sformatf("cont_dq0_%0d", c), 32'(Dq[7:0]),  32'h11);
            if (exp_acq == 2'b10) check($sformatf("cont_dq1_%0d", c), 32'(Dq[15:8]), 32'h22);
            if (c == 11) rden = 2'b00;
            tick();
        end

        // Reset during WR: write still lands, everything else back to reset.
        wren = 2'b01; Address[7:0] = 8'h30; Din[7:0] = 8'h5A;
        tick();
        check("rstwr_ramwren", 32'(RAMwren), 32'h1);
        rst = 1'b1; wren = 2'b00;
        tick();
        check("rstwr_acq",     32'(acq),        32'h0);
        check("rstwr_ramwren", 32'(RAMwren),    32'h0);
        check("rstwr_ramaddr", 32'(RAMAddress), 32'h0);
        check("rstwr_mem",     32'(mem[8'h30]), 32'h5A);
        rst = 1'b0;
        tick();
        check("rstwr_idle_acq", 32'(acq),     32'h0);
        check("rstwr_idle_wen", 32'(RAMwren), 32'h0);

        // Reset during RD: no acq, no data; core1 then granted fresh.
        rden = 2'b10; Address[15:8] = 8'h30;
        tick();
        check("rstrd_rd_acq", 32'(acq), 32'h0);
        rst = 1'b1;
        tick();
        check("rstrd_acq", 32'(acq),      32'h0);
        check("rstrd_dq1", 32'(Dq[15:8]), 32'h0);
        rst = 1'b0;
        tick();
        check("rstrd_again_rd_acq", 32'(acq), 32'h0);
        tick();
        check("rstrd_again_acq", 32'(acq),      32'h2);
        check("rstrd_again_dq1", 32'(Dq[15:8]), 32'h5A);
        rden = 2'b00;
        tick();

        // Core0 read moves ptr to 1; reset mid-read of core1 returns ptr to 0.
        rden = 2'b01; Address[7:0] = 8'h01;
        tick();
        tick();
        check("pre_acq", 32'(acq),     32'h1);
        check("pre_dq0", 32'(Dq[7:0]), 32'h11);
        rden = 2'b00;
        tick();
        rden = 2'b10; Address[15:8] = 8'h02;
        tick();
        rst = 1'b1; rden = 2'b11;
        tick();
        check("ptr_rst_acq", 32'(acq), 32'h0);
        check("ptr_rst_dq",  32'(Dq),  32'h0);
        rst = 1'b0;
        tick();
        tick();
        check("ptr_first_acq", 32'(acq),     32'h1);
        check("ptr_first_dq0", 32'(Dq[7:0]), 32'h11);
        rden = 2'b10;
        tick();
        tick();
        tick();
        check("ptr_second_acq", 32'(acq),      32'h2);
        check("ptr_second_dq1", 32'(Dq[15:8]), 32'h22);
        rden = 2'b00;
        tick();
        check("final_acq", 32'(acq), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
